mem_arbiter: RTL
================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter: WAIT, default 2, memory access cycles per transaction; legal range 1..15.
REQ-002 Port: clk  input  1  clock; all state updates on rising edge.
REQ-003 Port: rst  input  1  reset, asynchronous, active-high.
REQ-004 Port: req0, req1  input  1 each  access request from master 0 (CPU) / master 1 (loader/debug).
REQ-005 Port: we0, we1  input  1 each  per-master write select; 0 = read.
REQ-006 Port: addr0, addr1  input  32 each  per-master word address.
REQ-007 Port: wdata0, wdata1  input  32 each  per-master write data.
REQ-008 Port: ack0, ack1  output  1 each  one-cycle completion pulse to the owning master.
REQ-009 Port: rdata  output  32  registered read data; valid while ack0 or ack1 is high.
REQ-010 Port: stall0, stall1  output  1 each  combinational reqN & ~ackN; used by the requester to hold its clock.
REQ-011 Port: gnt  output  2  one-hot owner during BUSY and DONE; 0 otherwise.
REQ-012 Port: mem_addr, mem_wdata  output  32 each  latched address and write data to the single-port data memory.
REQ-013 Port: mem_re, mem_we  output  1 each  memory read / write strobes.
REQ-014 Port: mem_rdata  input  32  memory read data, combinational from mem_addr.

Function
REQ-015 FSM states SHALL be IDLE, BUSY, DONE.
REQ-016 IDLE with any req high SHALL select one master, latch its we/addr/wdata and id, load the wait counter with WAIT, and go to BUSY.
REQ-017 Selection SHALL be round-robin: a lone requester wins; if both request, the master not granted last wins.
REQ-018 BUSY SHALL last exactly WAIT cycles; the counter decrements once per cycle, and BUSY exits to DONE on the cycle the counter equals 1.
REQ-019 mem_re SHALL be high on every BUSY cycle of a read; mem_we SHALL be high only on the final BUSY cycle of a write, so each write is exactly one strobe.
REQ-020 On the final BUSY cycle of a read, rdata SHALL capture mem_rdata; writes SHALL leave rdata unchanged.
REQ-021 DONE SHALL last one cycle: ack of the owner high, last-granted pointer updated to the owner, next state IDLE.
REQ-022 Latency: request sampled in IDLE at cycle 0 gives BUSY at cycles 1..WAIT and ack at cycle WAIT+1.
REQ-023 Throughput: one transaction per WAIT+2 cycles; a new request is accepted only in IDLE.
REQ-024 Requester inputs SHALL be ignored after latching; req deasserted during BUSY SHALL NOT abort the transaction, and ack is still pulsed.
REQ-025 A request arriving during BUSY/DONE from either master SHALL wait; it is not lost while held high.
REQ-026 mem_re and mem_we SHALL never be high together; both SHALL be 0 in IDLE and DONE.
REQ-027 No address decoding or range checking; mem_addr SHALL equal the latched address unmodified.

Reset
REQ-028 rst high SHALL immediately force state IDLE, counter 0, gnt 0, ack0/ack1 0, mem_re/mem_we 0, rdata 0, mem_addr/mem_wdata 0.
REQ-029 Reset SHALL set the last-granted pointer to master 1, so master 0 wins the first contention.
REQ-030 Reset during BUSY SHALL abandon the transaction with no ack and no further memory strobe.

Verification (WAIT=2, cycle 0 = first IDLE edge sampling req)
REQ-031 Read: req0=1, we0=0, addr0=0x10, mem_rdata=0xDEADBEEF -> mem_re cycles 1-2, ack0 cycle 3, rdata=0xDEADBEEF, stall0 high cycles 0-2.
REQ-032 Write: req1=1, we1=1, addr1=0x20, wdata1=0x55 -> mem_we high only cycle 2 with mem_addr=0x20 and mem_wdata=0x55; ack1 cycle 3; rdata unchanged.
REQ-033 Contention: req0 and req1 held continuously after reset -> acks at cycles 3 (m0), 7 (m1), 11 (m0), 15 (m1), strictly alternating.
REQ-034 Reset in BUSY: write from m0, rst pulsed at cycle 1 -> mem_we never high, no ack, gnt=0; the next contention grants m0.
REQ-035 Abandoned request: req0 read dropped at cycle 1 -> mem_re still high cycles 1-2, ack0 at cycle 3, FSM back in IDLE at cycle 4.

Source files
------------

// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: request, completion and memory-side signals of the two-master arbiter
interface mem_arbiter_if;
    logic        req0;
    logic        req1;
    logic        we0;
    logic        we1;
    logic [31:0] addr0;
    logic [31:0] addr1;
    logic [31:0] wdata0;
    logic [31:0] wdata1;
    logic        ack0;
    logic        ack1;
    logic [31:0] rdata;
    logic        stall0;
    logic        stall1;
    logic [1:0]  gnt;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_re;
    logic        mem_we;
    logic [31:0] mem_rdata;

    modport slave (
        input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_rdata,
        output ack0, ack1, rdata, stall0, stall1, gnt, mem_addr, mem_wdata, mem_re, mem_we
    );

    modport master (
        output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_rdata,
        input  ack0, ack1, rdata, stall0, stall1, gnt, mem_addr, mem_wdata, mem_re, mem_we
    );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin two-master arbiter in front of a fixed-latency single-port memory
module mem_arbiter #(
    parameter int WAIT = 2
) (
    input logic         clk,
    input logic         rst,
    mem_arbiter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t      state;
    state_t      state_n;
    logic [3:0]  cnt;
    logic        owner;
    logic        last;
    logic        lat_we;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [31:0] rdata_q;
    logic        pick;
    logic        any_req;
    logic        last_beat;

    // State register; reset abandons any transaction in flight
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    // Next state, arbitration choice and all combinational outputs
    always_comb begin
        any_req    = bus.req0 | bus.req1;
        pick       = (bus.req0 & bus.req1) ? ~last : bus.req1;
        last_beat  = (state == BUSY) && (cnt == 4'd1);
        state_n    = (state == IDLE) ? (any_req ? BUSY : IDLE) :
                     (state == BUSY) ? (last_beat ? DONE : BUSY) : IDLE;
        bus.gnt    = (state == IDLE) ? 2'b00 : (owner ? 2'b10 : 2'b01);
        bus.ack0   = (state == DONE) & ~owner;
        bus.ack1   = (state == DONE) & owner;
        bus.mem_re = (state == BUSY) & ~lat_we;
        bus.mem_we = last_beat & lat_we;
        bus.stall0 = bus.req0 & ~bus.ack0;
        bus.stall1 = bus.req1 & ~bus.ack1;
    end

    // Latch the winner's request, count the access and capture read data on its last beat
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt     <= 4'd0;
            owner   <= 1'b0;
            last    <= 1'b1;
            lat_we  <= 1'b0;
            addr_q  <= 32'd0;
            wdata_q <= 32'd0;
            rdata_q <= 32'd0;
        end else begin
            if (state == IDLE && any_req) begin
                owner   <= pick;
                lat_we  <= pick ? bus.we1 : bus.we0;
                addr_q  <= pick ? bus.addr1 : bus.addr0;
                wdata_q <= pick ? bus.wdata1 : bus.wdata0;
                cnt     <= 4'(WAIT);
            end
            if (state == BUSY) cnt <= cnt - 4'd1;
            if (last_beat && !lat_we) rdata_q <= bus.mem_rdata;
            if (state == DONE) last <= owner;
        end
    end

    assign bus.mem_addr  = addr_q;
    assign bus.mem_wdata = wdata_q;
    assign bus.rdata     = rdata_q;
endmodule
